// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_pkg
// Description : Shared types and constants for the register-file writeback
//               arbiter (grant encoding, conflict counter sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LD  = 1'b1
    } grant_e;

    localparam int unsigned c_CNT_W = 16;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = {c_CNT_W{1'b1}};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = {{(c_CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [c_CNT_W-1:0] sat_inc(input logic [c_CNT_W-1:0] v);
        logic [c_CNT_W-1:0] r;
        r = (v == c_CNT_MAX) ? v : v + c_CNT_ONE;
        return r;
    endfunction

endpackage : rf_wb_arbiter_pkg
`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_if
// Description : Requester, stall and register-file write bundle for the
//               writeback arbiter. master = requesters/RF side, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    import rf_wb_arbiter_pkg::*;

    logic                alu_valid;
    logic [AW-1:0]       alu_rd;
    logic [DW-1:0]       alu_data;
    logic                alu_ready;

    logic                ld_valid;
    logic [AW-1:0]       ld_rd;
    logic [DW-1:0]       ld_data;
    logic                ld_ready;

    logic                wb_stall;

    logic                rf_we;
    logic [AW-1:0]       rf_waddr;
    logic [DW-1:0]       rf_wdata;
    logic [c_CNT_W-1:0]  conflict_cnt;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output wb_stall,
        input  rf_we, rf_waddr, rf_wdata, conflict_cnt
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  wb_stall,
        output rf_we, rf_waddr, rf_wdata, conflict_cnt
    );

endinterface : rf_wb_arbiter_if
`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. req[0]=ALU, req[1]=LD; on a tie
//               the requester that did not win last is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  grant_e     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == GNT_LD) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Arbitrates ALU and load-unit writebacks onto a single
//               register-file write port with a one-cycle registered stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);

    grant_e             r_last_grant;
    grant_e             w_last_grant_nxt;

    logic [1:0]         w_req;
    logic [1:0]         w_gnt;
    logic               w_open;
    logic               w_alu_hs;
    logic               w_ld_hs;
    logic               w_any_hs;
    logic               w_tie;
    logic [AW-1:0]      w_hs_rd;
    logic [DW-1:0]      w_hs_data;

    logic               r_we;
    logic [AW-1:0]      r_waddr;
    logic [DW-1:0]      r_wdata;
    logic [c_CNT_W-1:0] r_conflict_cnt;

    assign w_req = {bus.ld_valid, bus.alu_valid};

    rr_arb2 u_rr_arb2 (
        .req  (w_req),
        .last (r_last_grant),
        .gnt  (w_gnt)
    );

    // Port is usable only when not stalled and not in reset.
    assign w_open = ~bus.wb_stall & ~rst;

    // Grant state: register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GNT_LD;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Grant state: next-state
    always_comb begin
        w_last_grant_nxt = r_last_grant;
        if (w_alu_hs) begin
            w_last_grant_nxt = GNT_ALU;
        end else if (w_ld_hs) begin
            w_last_grant_nxt = GNT_LD;
        end
    end

    // Grant state: outputs (handshake strobes)
    always_comb begin
        w_alu_hs = w_gnt[0] & bus.alu_valid & w_open;
        w_ld_hs  = w_gnt[1] & bus.ld_valid  & w_open;
        w_any_hs = w_alu_hs | w_ld_hs;
    end

    assign bus.alu_ready = w_alu_hs;
    assign bus.ld_ready  = w_ld_hs;

    assign w_hs_rd   = w_ld_hs ? bus.ld_rd   : bus.alu_rd;
    assign w_hs_data = w_ld_hs ? bus.ld_data : bus.alu_data;
    assign w_tie     = bus.alu_valid & bus.ld_valid;

    // r0 writes are accepted but leave the stage's address/data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_any_hs && (w_hs_rd != '0)) begin
            r_we    <= 1'b1;
            r_waddr <= w_hs_rd;
            r_wdata <= w_hs_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (w_tie && w_any_hs) begin
            r_conflict_cnt <= sat_inc(r_conflict_cnt);
        end
    end

    assign bus.rf_we        = r_we;
    assign bus.rf_waddr     = r_waddr;
    assign bus.rf_wdata     = r_wdata;
    assign bus.conflict_cnt = r_conflict_cnt;

endmodule : rf_wb_arbiter
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Directed self-checking bench for rf_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int c_DW = 32;
    localparam int c_AW = 5;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;
    bit chk_en;

    rf_wb_arbiter_if #(.DW(c_DW), .AW(c_AW)) bus ();

    rf_wb_arbiter #(.DW(c_DW), .AW(c_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = nobody, 1 = ALU, 2 = LD
    int          m_last;
    int          m_win;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_cnt;

    function automatic int pick(bit r, bit st, bit av, bit lv, int last);
        if (r || st)   return 0;
        if (av && lv)  return (last == 2) ? 1 : 2;
        if (av)        return 1;
        if (lv)        return 2;
        return 0;
    endfunction

    always_comb m_win = pick(rst, bus.wb_stall, bus.alu_valid, bus.ld_valid, m_last);

    always @(posedge clk) begin
        if (rst) begin
            m_we <= 0; m_addr <= 0; m_data <= 0; m_cnt <= 0; m_last <= 2;
        end else if (m_win != 0) begin
            m_last <= m_win;
            if (bus.alu_valid && bus.ld_valid && m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (m_win == 1) begin
                m_we <= (bus.alu_rd != 0);
                if (bus.alu_rd != 0) begin m_addr <= bus.alu_rd; m_data <= bus.alu_data; end
            end else begin
                m_we <= (bus.ld_rd != 0);
                if (bus.ld_rd != 0) begin m_addr <= bus.ld_rd; m_data <= bus.ld_data; end
            end
        end else begin
            m_we <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("alu_ready",    64'(bus.alu_ready),    64'(m_win == 1));
            check("ld_ready",     64'(bus.ld_ready),     64'(m_win == 2));
            check("rf_we",        64'(bus.rf_we),        64'(m_we));
            check("rf_waddr",     64'(bus.rf_waddr),     64'(m_addr));
            check("rf_wdata",     64'(bus.rf_wdata),     64'(m_data));
            check("conflict_cnt", 64'(bus.conflict_cnt), 64'(m_cnt));
        end
    end

    task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld, input bit st);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
        bus.ld_valid  = lv; bus.ld_rd  = lrd; bus.ld_data  = ld;
        bus.wb_stall  = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; chk_en = 0;
        rst = 1'b1;
        drive(1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 0);

        // Reset held two cycles with both valids high
        step();
        chk_en = 1;
        @(negedge clk);
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("rst_ld_ready",  64'(bus.ld_ready),  64'd0);
        check("rst_rf_we",     64'(bus.rf_we),     64'd0);
        check("rst_cnt",       64'(bus.conflict_cnt), 64'd0);
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        // Single ALU requester
        drive(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0);
        @(negedge clk);
        check("single_alu_ready", 64'(bus.alu_ready), 64'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("single_rf_we",    64'(bus.rf_we),    64'd1);
        check("single_rf_waddr", 64'(bus.rf_waddr), 64'd3);
        check("single_rf_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        step();

        // Tie right after reset: ALU first, then LD
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0);
        @(negedge clk);
        check("tie0_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("tie0_ld_ready",  64'(bus.ld_ready),  64'd0);
        step();
        @(negedge clk);
        check("tie1_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("tie1_ld_ready",  64'(bus.ld_ready),  64'd1);
        check("tie1_rf_waddr",  64'(bus.rf_waddr),  64'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("tie_rf_waddr", 64'(bus.rf_waddr),     64'd2);
        check("tie_rf_wdata", 64'(bus.rf_wdata),     64'hB2);
        check("tie_cnt",      64'(bus.conflict_cnt), 64'd2);
        step();

        // Load to r0 is accepted and discarded
        drive(0, 0, 0, 1, 5'd0, 32'h1234, 0);
        @(negedge clk);
        check("r0_ld_ready", 64'(bus.ld_ready), 64'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("r0_rf_we",    64'(bus.rf_we),    64'd0);
        check("r0_rf_waddr", 64'(bus.rf_waddr), 64'd2);
        step();

        // Stall three cycles; last_grant (LD) must survive it
        drive(1, 5'd7, 32'h77, 0, 0, 0, 1);
        repeat (3) begin
            @(negedge clk);
            check("stall_alu_ready", 64'(bus.alu_ready), 64'd0);
            check("stall_rf_we",     64'(bus.rf_we),     64'd0);
            step();
        end
        drive(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 0);
        @(negedge clk);
        check("rel_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("rel_ld_ready",  64'(bus.ld_ready),  64'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rel_rf_we",    64'(bus.rf_we),    64'd1);
        check("rel_rf_waddr", 64'(bus.rf_waddr), 64'd7);
        step();
        @(negedge clk);
        check("rel_rf_we_once", 64'(bus.rf_we), 64'd0);

        // Back-to-back from alternating requesters
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drive(1, 5'(10 + i), 32'(32'h100 * i + 1), 0, 0, 0, 0);
            else            drive(0, 0, 0, 1, 5'(20 + i), 32'(32'h300 * i + 3), 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        // Handshake attempted while reset is asserted
        drive(1, 5'd9, 32'h99, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rsths_alu_ready", 64'(bus.alu_ready), 64'd0);
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rsths_rf_we", 64'(bus.rf_we), 64'd0);
        step();

        // Counter saturation
        drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("sat_cnt", 64'(bus.conflict_cnt), 64'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sat_hold", 64'(bus.conflict_cnt), 64'hFFFF);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rf_wb_arbiter
`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DW, default 32, write-data width in bits.
REQ-002 Parameter AW, default 5, register-address width in bits.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous, active-high reset.
REQ-005 Port alu_valid, input, 1, ALU requester holds a pending writeback.
REQ-006 Port alu_rd, input, AW, ALU destination register.
REQ-007 Port alu_data, input, DW, ALU result.
REQ-008 Port alu_ready, output, 1, ALU writeback accepted this cycle.
REQ-009 Port ld_valid, input, 1, load-unit requester holds a pending writeback.
REQ-010 Port ld_rd, input, AW, load destination register.
REQ-011 Port ld_data, input, DW, load result.
REQ-012 Port ld_ready, output, 1, load writeback accepted this cycle.
REQ-013 Port wb_stall, input, 1, when high, the register-file write port is unavailable.
REQ-014 Port rf_we, output, 1, drives the register-file write enable.
REQ-015 Port rf_waddr, output, AW, drives the register-file write address.
REQ-016 Port rf_wdata, output, DW, drives the register-file write data.
REQ-017 Port conflict_cnt, output, 16, count of cycles in which one requester lost arbitration.

Function
REQ-018 A handshake on requester X SHALL occur when X_valid and X_ready are both high in the same cycle.
REQ-019 X_ready SHALL be combinational: high only if X is granted, X_valid is high and wb_stall is low; alu_ready and ld_ready SHALL never both be high.
REQ-020 With one requester valid and wb_stall low, that requester SHALL be granted.
REQ-021 With both requesters valid, the requester not in last_grant SHALL be granted (round-robin).
REQ-022 last_grant SHALL update to the winner only on a handshake and SHALL hold otherwise.
REQ-023 A handshake SHALL register rd and data into the output stage; rf_we SHALL pulse high for exactly one cycle on the following cycle (latency 1).
REQ-024 A handshake with rd==0 SHALL be accepted, with rf_we held low in the following cycle (write to r0 discarded).
REQ-025 rf_waddr and rf_wdata SHALL hold their last values when rf_we is low.
REQ-026 While wb_stall is high, no handshake SHALL occur, last_grant SHALL hold, and rf_we SHALL be low in the next cycle.
REQ-027 conflict_cnt SHALL increment by 1 in every cycle with both valids high, wb_stall low and one handshake, and SHALL saturate at 0xFFFF.
REQ-028 A requester SHALL keep rd and data stable while valid is high without ready; the block relies on this and does not check it.
REQ-029 Back-to-back handshakes SHALL be supported, one per cycle, with one rf_we pulse per cycle.

Reset
REQ-030 While rst is high at a clk edge, the following SHALL be forced: rf_we=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0, last_grant=LD (so the ALU wins the first tie).
REQ-031 alu_ready and ld_ready SHALL be low during any cycle with rst high.
REQ-032 A handshake in the cycle rst is asserted SHALL be discarded, with no rf_we pulse afterward.

Structure
REQ-033 A shared package SHALL hold the grant enum {GNT_ALU, GNT_LD} and the conflict counter width constant (16).
REQ-034 The round-robin arbiter SHALL be a separate sub-module, rr_arb2, with inputs req[1:0] and last and output gnt[1:0].
REQ-035 The output stage SHALL connect directly to the register file's RegWrite, Write_Register and Write_Data, with no other logic.

Verification
REQ-036 Reset: rst=1 for 2 cycles with both valids high -> readies low, rf_we=0, conflict_cnt=0.
REQ-037 Single requester: alu_valid with rd=3, data=0xDEADBEEF -> alu_ready in the same cycle; next cycle rf_we=1, waddr=3, wdata=0xDEADBEEF.
REQ-038 Tie after reset: both valid (alu rd=1, ld rd=2) held 2 cycles -> ALU is granted in cycle 0 and LD in cycle 1; writes to r1 then r2; conflict_cnt=2.
REQ-039 r0 discard: ld_valid with rd=0, data=0x1234 -> ld_ready=1; next cycle rf_we=0.
REQ-040 Stall: wb_stall=1 for 3 cycles with alu_valid high -> no ready, no rf_we; after release, exactly one write occurs and last_grant is unchanged by the stall.
REQ-041 Saturation: force both valid for 65540 cycles -> conflict_cnt=0xFFFF and holds.
